// File: rtl/iopmp_pkg.sv
// Shared IOPMP register offsets plus the types used by the record-drain logic.
package iopmp_pkg;

    localparam logic [31:0] IOPMP_CTL_OFF      = 32'h0000_0000;
    localparam logic [31:0] IOPMP_RCD_OFF      = 32'h0000_0060;
    localparam logic [31:0] IOPMP_RCD_ADDR_OFF = 32'h0000_0068;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_RCD  = 2'd1,
        RD_ADDR = 2'd2,
        CLR     = 2'd3
    } drn_state_e;

    // rcd: [31] ILLCGT, [30:28] EXTRA, [27:15] LEN, [14] R, [13:0] SID
    typedef struct packed {
        logic [31:0] rcd;
        logic [63:0] addr;
    } iopmp_rec_t;

endpackage

// File: rtl/iopmp_rcd_fifo.sv
// First-word fall-through record FIFO; pointers wrap modulo DEPTH (power of two).
module iopmp_rcd_fifo #(
    parameter int  DEPTH = 4,
    parameter type rec_t = logic [95:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push,
    input  rec_t push_data,
    input  logic pop,
    output logic valid,
    output rec_t head,
    output logic full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == FULL_CNT);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & valid;
    assign do_push = push & ~full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the head is only observed while valid is high.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/iopmp_rcd_drainer.sv
// Polls the IOPMP violation record, drains illegal records into a FIFO and
// shares the IOPMP config port with a host that has priority while idle.
//
// state   | meaning
// IDLE    | poll counter runs; host may access the config port
// RD_RCD  | read iopmp_rcd, continue only if ILLCGT is set
// RD_ADDR | read iopmp_rcd_addr
// CLR     | W1C the record and push it into the FIFO
module iopmp_rcd_drainer
    import iopmp_pkg::*;
#(
    parameter logic [31:0] IOPMP_BASE  = 32'h5000_0000,
    parameter int          POLL_CYCLES = 16,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [31:0] host_addr_i,
    input  logic [63:0] host_wdata_i,
    output logic        host_gnt_o,
    output logic [63:0] host_rdata_o,
    output logic [31:0] address_cfg,
    output logic        en_cfg,
    output logic        we_cfg,
    output logic [63:0] wdata_cfg,
    input  logic [63:0] rdata_cfg,
    output logic        rec_valid_o,
    input  logic        rec_ready_i,
    output logic [31:0] rec_rcd_o,
    output logic [63:0] rec_addr_o,
    output logic        irq_o
);

    localparam logic [15:0] RELOAD    = 16'(POLL_CYCLES - 1);
    localparam logic [31:0] RCD_ADR   = IOPMP_BASE + IOPMP_RCD_OFF;
    localparam logic [31:0] RCDA_ADR  = IOPMP_BASE + IOPMP_RCD_ADDR_OFF;

    drn_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rcd_q;
    logic [63:0] addr_q;
    logic        host_req;
    logic        push;
    logic        fifo_valid;
    logic        fifo_full;
    iopmp_rec_t  push_rec;
    iopmp_rec_t  head_rec;

    // Gating with reset keeps every output low while rst_ni is asserted.
    assign host_req = host_req_i & rst_ni;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        host_gnt_o  = 1'b0;
        en_cfg      = 1'b0;
        we_cfg      = 1'b0;
        address_cfg = '0;
        wdata_cfg   = '0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_req) begin
                    host_gnt_o  = 1'b1;
                    en_cfg      = 1'b1;
                    we_cfg      = host_we_i;
                    address_cfg = host_addr_i;
                    wdata_cfg   = host_wdata_i;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!host_req && !fifo_full) begin
                    state_d = RD_RCD;
                    cnt_d   = RELOAD;
                end
            end
            RD_RCD: begin
                en_cfg      = 1'b1;
                address_cfg = RCD_ADR;
                state_d     = rdata_cfg[31] ? RD_ADDR : IDLE;
            end
            RD_ADDR: begin
                en_cfg      = 1'b1;
                address_cfg = RCDA_ADR;
                state_d     = CLR;
            end
            CLR: begin
                en_cfg      = 1'b1;
                we_cfg      = 1'b1;
                address_cfg = RCD_ADR;
                wdata_cfg   = 64'h1;
                push        = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign host_rdata_o = host_gnt_o ? rdata_cfg : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= RELOAD;
            rcd_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == RD_RCD)  rcd_q  <= rdata_cfg[31:0];
            if (state_q == RD_ADDR) addr_q <= rdata_cfg;
        end
    end

    assign push_rec.rcd  = rcd_q;
    assign push_rec.addr = addr_q;

    iopmp_rcd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .rec_t (iopmp_rec_t)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (push),
        .push_data (push_rec),
        .pop       (rec_ready_i),
        .valid     (fifo_valid),
        .head      (head_rec),
        .full      (fifo_full)
    );

    assign rec_valid_o = fifo_valid;
    assign irq_o       = fifo_valid;
    assign rec_rcd_o   = fifo_valid ? head_rec.rcd  : '0;
    assign rec_addr_o  = fifo_valid ? head_rec.addr : '0;

endmodule

// File: tb/tb_iopmp_rcd_drainer.sv
// Directed bench for iopmp_rcd_drainer with a small queue-based IOPMP record model.
module tb_iopmp_rcd_drainer;

    localparam int          P        = 8;
    localparam logic [31:0] BASE     = 32'h5000_0000;
    localparam logic [31:0] A_CTL    = BASE + 32'h0000_0000;
    localparam logic [31:0] A_RCD    = BASE + 32'h0000_0060;
    localparam logic [31:0] A_RCDA   = BASE + 32'h0000_0068;
    localparam logic [63:0] CTL_VAL  = 64'hDEAD_BEEF_0123_4567;

    logic        clk;
    logic        rst_n;
    logic        host_req, host_we;
    logic [31:0] host_addr;
    logic [63:0] host_wdata;
    logic        host_gnt;
    logic [63:0] host_rdata;
    logic [31:0] address_cfg;
    logic        en_cfg, we_cfg;
    logic [63:0] wdata_cfg, rdata_cfg;
    logic        rec_valid, rec_ready;
    logic [31:0] rec_rcd;
    logic [63:0] rec_addr;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ev_rcd  [16];
    logic [63:0] ev_addr [16];
    logic [3:0]  ev_head = '0;
    logic [3:0]  ev_tail = '0;
    logic        pending;

    int cyc = 0;
    int n_rd_rcd = 0, n_rd_addr = 0, n_wr = 0, n_other = 0;
    int last_rd_rcd = 0, prev_rd_rcd = 0, last_rd_addr = 0, last_wr = 0;

    iopmp_rcd_drainer #(
        .IOPMP_BASE  (BASE),
        .POLL_CYCLES (P),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .host_req_i   (host_req),
        .host_we_i    (host_we),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata),
        .host_gnt_o   (host_gnt),
        .host_rdata_o (host_rdata),
        .address_cfg  (address_cfg),
        .en_cfg       (en_cfg),
        .we_cfg       (we_cfg),
        .wdata_cfg    (wdata_cfg),
        .rdata_cfg    (rdata_cfg),
        .rec_valid_o  (rec_valid),
        .rec_ready_i  (rec_ready),
        .rec_rcd_o    (rec_rcd),
        .rec_addr_o   (rec_addr),
        .irq_o        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pending   = (ev_head != ev_tail);
    assign rdata_cfg = (address_cfg == A_RCD)  ? (pending ? {32'h0, ev_rcd[ev_head]} : 64'h0) :
                       (address_cfg == A_RCDA) ? (pending ? ev_addr[ev_head] : 64'h0) :
                       (address_cfg == A_CTL)  ? CTL_VAL : 64'h0;

    // IOPMP side: W1C retires the pending record; transaction log for timing checks.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en_cfg && !host_gnt) begin
            if (!we_cfg && address_cfg == A_RCD) begin
                n_rd_rcd    <= n_rd_rcd + 1;
                prev_rd_rcd <= last_rd_rcd;
                last_rd_rcd <= cyc;
            end else if (!we_cfg && address_cfg == A_RCDA) begin
                n_rd_addr    <= n_rd_addr + 1;
                last_rd_addr <= cyc;
            end else if (we_cfg && address_cfg == A_RCD && wdata_cfg == 64'h1) begin
                n_wr    <= n_wr + 1;
                last_wr <= cyc;
                if (pending) ev_head <= ev_head + 1'b1;
            end else begin
                n_other <= n_other + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic [31:0] r, input logic [63:0] a);
        ev_rcd[ev_tail]  = r;
        ev_addr[ev_tail] = a;
        ev_tail          = ev_tail + 1'b1;
    endtask

    task automatic wait_rd_rcd(input int budget, input string tag);
        int start = n_rd_rcd;
        int k = 0;
        while (n_rd_rcd == start && k < budget) begin
            step();
            k++;
        end
        chk(tag, 64'(n_rd_rcd != start), 64'd1);
    endtask

    task automatic wait_wr(input int target, input int budget, input string tag);
        int k = 0;
        while (n_wr < target && k < budget) begin
            step();
            k++;
        end
        chk(tag, 64'(n_wr >= target), 64'd1);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] r, input logic [63:0] a);
        chk({tag, "_valid"}, 64'(rec_valid), 64'd1);
        chk({tag, "_rcd"}, 64'(rec_rcd), 64'(r));
        chk({tag, "_addr"}, rec_addr, a);
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
    endtask

    initial begin
        int w0, r0, a0;
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, a0;
        logic [31:0] exp_r [5];
        logic [63:0] exp_a [5];

        // Reset: outputs low even with a host request pending.
        rst_n = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = A_CTL;
        host_wdata = 64'h0; rec_ready = 1'b0;
        #2;
        chk("rst_gnt", 64'(host_gnt), 64'd0);
        chk("rst_en", 64'(en_cfg), 64'd0);
        chk("rst_addr", 64'(address_cfg), 64'd0);
        chk("rst_rdata", host_rdata, 64'd0);
        chk("rst_valid", 64'(rec_valid), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        step(); step(); step();
        host_req = 1'b0;
        rst_n = 1'b1;

        // Empty IOPMP: single-read polls, P idle cycles apart.
        wait_rd_rcd(3 * P + 10, "poll1_seen");
        wait_rd_rcd(3 * P + 10, "poll2_seen");
        chk("poll_interval", 64'(last_rd_rcd - prev_rd_rcd), 64'(P + 1));
        chk("legal_no_rdaddr", 64'(n_rd_addr), 64'd0);
        chk("legal_no_wr", 64'(n_wr), 64'd0);
        chk("legal_fifo_empty", 64'(rec_valid), 64'd0);

        // Single illegal record.
        push_ev(32'h8000_4001, 64'h4007);
        w0 = n_wr; r0 = n_rd_rcd; a0 = n_rd_addr;
        wait_wr(w0 + 1, 3 * P + 10, "drain1_done");
        chk("drain1_rdaddr_lat", 64'(last_rd_addr - last_rd_rcd), 64'd1);
        chk("drain1_wr_lat", 64'(last_wr - last_rd_rcd), 64'd2);
        chk("drain1_nrd", 64'(n_rd_rcd - r0), 64'd1);
        chk("drain1_nrda", 64'(n_rd_addr - a0), 64'd1);
        chk("drain1_irq", 64'(irq), 64'd1);
        chk("drain1_retired", 64'(pending), 64'd0);
        pop_chk("drain1", 32'h8000_4001, 64'h4007);
        chk("drain1_empty", 64'(rec_valid), 64'd0);
        chk("drain1_irq_clr", 64'(irq), 64'd0);

        // Five records, consumer stalled, depth 4.
        exp_r[0] = 32'h8000_0011; exp_a[0] = 64'h1000;
        exp_r[1] = 32'hC000_8022; exp_a[1] = 64'h2000;
        exp_r[2] = 32'h8123_4033; exp_a[2] = 64'hFFFF_0000_3000;
        exp_r[3] = 32'hF000_0044; exp_a[3] = 64'h4000;
        exp_r[4] = 32'h8000_7FFF; exp_a[4] = 64'h5000;
        for (int i = 0; i < 5; i++) push_ev(exp_r[i], exp_a[i]);
        w0 = n_wr;
        wait_wr(w0 + 4, 8 * (P + 4), "full_fill");
        r0 = n_rd_rcd;
        for (int i = 0; i < 3 * (P + 1) + 3; i++) step();
        chk("full_no_poll", 64'(n_rd_rcd - r0), 64'd0);
        chk("full_no_wr", 64'(n_wr - w0), 64'd4);
        chk("full_pending", 64'(pending), 64'd1);
        pop_chk("fifo0", exp_r[0], exp_a[0]);
        wait_wr(w0 + 5, P + 3, "fifth_captured");
        for (int i = 1; i < 5; i++) pop_chk($sformatf("fifo%0d", i), exp_r[i], exp_a[i]);
        chk("fifo_drained", 64'(rec_valid), 64'd0);

        // Host read held across the poll instant defers the poll by one cycle.
        wait_rd_rcd(3 * P + 10, "host_align");
        for (int i = 0; i < P - 2; i++) step();
        host_req = 1'b1; host_we = 1'b0; host_addr = A_CTL;
        #1;
        chk("host_pre_gnt", 64'(host_gnt), 64'd1);
        step();
        chk("host_poll_gnt", 64'(host_gnt), 64'd1);
        chk("host_poll_rdata", host_rdata, CTL_VAL);
        chk("host_poll_addr", 64'(address_cfg), 64'(A_CTL));
        step();
        host_req = 1'b0;
        wait_rd_rcd(3 * P + 10, "host_deferred_poll");
        chk("host_defer_interval", 64'(last_rd_rcd - prev_rd_rcd), 64'(P + 2));

        // Host request during RD_ADDR waits until the sequence completes.
        push_ev(32'h8000_1234, 64'hABCD_0008);
        wait_rd_rcd(3 * P + 10, "seq_align");
        host_req = 1'b1; host_we = 1'b0; host_addr = A_CTL;
        #1;
        chk("rdaddr_addr", 64'(address_cfg), 64'(A_RCDA));
        chk("rdaddr_gnt", 64'(host_gnt), 64'd0);
        step();
        chk("clr_gnt", 64'(host_gnt), 64'd0);
        chk("clr_wdata", wdata_cfg, 64'h1);
        step();
        chk("idle_gnt", 64'(host_gnt), 64'd1);
        chk("idle_rdata", host_rdata, CTL_VAL);
        host_req = 1'b0;
        pop_chk("seq_rec", 32'h8000_1234, 64'hABCD_0008);

        // Reset during RD_ADDR abandons the sequence; record drained again later.
        push_ev(32'h8000_7777, 64'h1_2345_6788);
        wait_rd_rcd(3 * P + 10, "rst_align");
        w0 = n_wr;
        rst_n = 1'b0;
        #1;
        chk("midrst_en", 64'(en_cfg), 64'd0);
        chk("midrst_addr", 64'(address_cfg), 64'd0);
        chk("midrst_we", 64'(we_cfg), 64'd0);
        chk("midrst_valid", 64'(rec_valid), 64'd0);
        step(); step();
        rst_n = 1'b1;
        chk("midrst_no_w1c", 64'(n_wr - w0), 64'd0);
        chk("midrst_pending", 64'(pending), 64'd1);
        wait_wr(w0 + 1, 3 * P + 10, "redrain_done");
        pop_chk("redrain", 32'h8000_7777, 64'h1_2345_6788);
        chk("no_stray_cfg", 64'(n_other), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iopmp_rcd_drainer.md
IOPMP_RCD_DRAINER -- requirements
Module: iopmp_rcd_drainer

Interface
REQ-001 SHALL have parameter IOPMP_BASE, default 32'h5000_0000, the IOPMP register base address.
REQ-002 SHALL have parameter POLL_CYCLES, default 16, the idle cycles between RCD polls (legal range 1..65535).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the record FIFO depth (power of two, at least 2).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async reset, active low.
REQ-005 host_req_i  in  1  host register access request.
REQ-006 host_we_i  in  1  host write (1) / read (0).
REQ-007 host_addr_i  in  32  host register address.
REQ-008 host_wdata_i  in  64  host write data.
REQ-009 host_gnt_o  out  1  host access performed this cycle.
REQ-010 host_rdata_o  out  64  host read data, valid when host_gnt_o=1.
REQ-011 address_cfg  out  32  IOPMP config address.
REQ-012 en_cfg  out  1  IOPMP config enable.
REQ-013 we_cfg  out  1  IOPMP config write enable.
REQ-014 wdata_cfg  out  64  IOPMP config write data.
REQ-015 rdata_cfg  in  64  IOPMP config read data, combinational in the same cycle.
REQ-016 rec_valid_o  out  1  FIFO head record valid.
REQ-017 rec_ready_i  in  1  consumer accepts the head record.
REQ-018 rec_rcd_o  out  32  captured iopmp_rcd: [31] ILLCGT, [30:28] EXTRA, [27:15] LEN, [14] R, [13:0] SID.
REQ-019 rec_addr_o  out  64  captured iopmp_rcd_addr.
REQ-020 irq_o  out  1  FIFO non-empty.

Function
REQ-021 FSM states SHALL be IDLE, RD_RCD, RD_ADDR, CLR; each non-IDLE state SHALL last exactly one cycle.
REQ-022 In IDLE the poll counter SHALL decrement each cycle; at zero, if the FIFO is not full, the FSM SHALL go to RD_RCD and reload the counter to POLL_CYCLES-1.
REQ-023 At zero with the FIFO full, the counter SHALL hold at zero and no poll SHALL occur, leaving the record pending in the IOPMP, so no record is lost.
REQ-024 RD_RCD SHALL drive en_cfg=1, we_cfg=0, address_cfg=IOPMP_BASE+IOPMP_RCD_OFF and capture rdata_cfg at the clock edge.
REQ-025 If the captured bit 31 is 0, the FSM SHALL return to IDLE; otherwise it SHALL go to RD_ADDR.
REQ-026 RD_ADDR SHALL read IOPMP_BASE+IOPMP_RCD_ADDR_OFF and capture 64 bits.
REQ-027 CLR SHALL write wdata_cfg=64'h1 (W1C) to IOPMP_BASE+IOPMP_RCD_OFF, push {rcd[31:0], addr} into the FIFO at the same edge, and then go to IDLE.
REQ-028 The host SHALL be granted only in IDLE and on a cycle the FSM does not leave IDLE; the RD_RCD..CLR sequence is atomic and the host SHALL wait.
REQ-029 When a host request coincides with a poll, the host SHALL win and the poll SHALL be deferred one cycle (counter holds at zero).
REQ-030 On a host grant the host signals SHALL drive the cfg port with en_cfg=1, host_rdata_o SHALL equal rdata_cfg combinationally, and host_gnt_o SHALL be 1 in that cycle.
REQ-031 When no owner is active, en_cfg=0, we_cfg=0, address_cfg=0 and wdata_cfg=0.
REQ-032 The FIFO SHALL be first-word fall-through: pop when rec_valid_o & rec_ready_i. A simultaneous push and pop when full cannot occur (REQ-023); a simultaneous push and pop otherwise SHALL keep the count unchanged.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH and the count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-034 On rst_ni low, the FSM SHALL go to IDLE, the counter SHALL load POLL_CYCLES-1, and the FIFO SHALL be emptied.
REQ-035 During reset all outputs SHALL be 0; a sequence in progress SHALL be abandoned, and its record stays in the IOPMP (no W1C issued).

Structure
REQ-036 The drainer FSM state enum and the record struct SHALL live in iopmp_pkg, alongside the existing IOPMP_RCD_OFF and IOPMP_RCD_ADDR_OFF.
REQ-037 The FIFO SHALL be a sub-module named iopmp_rcd_fifo, parameterised by depth and record type.

Verification
REQ-038 The IOPMP model holds rcd=32'h8000_4001 and rcd_addr=64'h4007 -> after the poll, exactly 3 cfg cycles (RD_RCD, RD_ADDR, CLR with wdata 1), then rec_valid_o=1 with rec_rcd_o=32'h8000_4001, rec_addr_o=64'h4007, and irq_o=1.
REQ-039 rcd bit 31 is 0 -> 1 read cycle only, no RD_ADDR or write, and the FIFO stays empty; the next poll follows POLL_CYCLES cycles later.
REQ-040 rec_ready_i=0 and 5 illegal events with FIFO_DEPTH=4 -> 4 records captured, no poll while full, and the fifth is captured within POLL_CYCLES+3 cycles after one pop, in order.
REQ-041 Host read of IOPMP_BASE+IOPMP_CTL_OFF held asserted across the poll instant -> host_gnt_o=1 that cycle, the poll is delayed one cycle, and rdata is passed unchanged.
REQ-042 Host request raised during RD_ADDR -> host_gnt_o=0 until the FSM returns to IDLE, then 1.
REQ-043 rst_ni pulsed low during RD_ADDR -> all outputs 0, FIFO empty, no W1C issued, and the record is re-drained after the next poll.
